// File: rtl/tt_sweep_if.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_if
// Description : Sweep handshake, pattern outputs and captured truth table.
//               The ones field exists only with TT_SWEEP_ONES_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface tt_sweep_if;
    logic         start;
    logic         f_in;
    logic         x0;
    logic         x1;
    logic         x2;
    logic         x3;
    logic         x4;
    logic         x5;
    logic         x6;
    logic         busy;
    logic [127:0] tt;
    logic         tt_valid;
`ifdef TT_SWEEP_ONES_COUNT_EN
    logic [7:0]   ones;

    modport master (
        output start, f_in,
        input  x0, x1, x2, x3, x4, x5, x6, busy, tt, tt_valid, ones
    );
    modport slave (
        input  start, f_in,
        output x0, x1, x2, x3, x4, x5, x6, busy, tt, tt_valid, ones
    );
`else
    modport master (
        output start, f_in,
        input  x0, x1, x2, x3, x4, x5, x6, busy, tt, tt_valid
    );
    modport slave (
        input  start, f_in,
        output x0, x1, x2, x3, x4, x5, x6, busy, tt, tt_valid
    );
`endif
endinterface
`default_nettype wire

// File: rtl/tt_sweep.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep
// Description : Drives all 128 patterns of a 7-input function and captures its
//               truth table. Optional popcount via TT_SWEEP_ONES_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_sweep (
    input  wire logic clk,
    input  wire logic rst,
    tt_sweep_if.slave bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SWEEP = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;
    localparam logic [6:0] c_LAST  = 7'd127;

    logic [1:0]   r_state;
    logic [6:0]   r_cnt;
    logic [127:0] r_tt;
    logic         w_sweep;

    assign w_sweep = (r_state == c_SWEEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 7'd0;
            r_tt    <= 128'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_cnt   <= 7'd0;
                        r_tt    <= 128'd0;
                        r_state <= c_SWEEP;
                    end
                end
                c_SWEEP: begin
                    // cnt wraps to 0 naturally on the last pattern
                    r_tt[r_cnt] <= bus.f_in;
                    r_cnt       <= r_cnt + 7'd1;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

`ifdef TT_SWEEP_ONES_COUNT_EN
    logic [7:0] r_ones;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ones <= 8'd0;
        end else if ((r_state == c_IDLE) && bus.start) begin
            r_ones <= 8'd0;
        end else if (w_sweep) begin
            r_ones <= r_ones + {7'd0, bus.f_in};
        end
    end

    assign bus.ones = r_ones;
`endif

    // Patterns are forced to zero outside SWEEP so the downstream logic idles.
    assign bus.x0 = w_sweep & r_cnt[0];
    assign bus.x1 = w_sweep & r_cnt[1];
    assign bus.x2 = w_sweep & r_cnt[2];
    assign bus.x3 = w_sweep & r_cnt[3];
    assign bus.x4 = w_sweep & r_cnt[4];
    assign bus.x5 = w_sweep & r_cnt[5];
    assign bus.x6 = w_sweep & r_cnt[6];

    assign bus.busy     = (r_state == c_SWEEP) || (r_state == c_DONE);
    assign bus.tt       = r_tt;
    assign bus.tt_valid = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_sweep
// Description : Directed self-checking bench for tt_sweep with a combinational
//               function model on f_in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_sweep;

    logic clk;
    logic rst;
    int   mode;
    int   checks;
    int   errors;
    logic [6:0] w_x;

    localparam logic [127:0] c_ALL1 = {128{1'b1}};
    localparam logic [127:0] c_X0   = {32{4'hA}};
    localparam logic [127:0] c_X6   = {{64{1'b1}}, {64{1'b0}}};
    localparam logic [127:0] c_MAJ  = {4{32'hFAFA_A0A0}};

    tt_sweep_if u_if ();

    tt_sweep u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    assign w_x = {u_if.x6, u_if.x5, u_if.x4, u_if.x3, u_if.x2, u_if.x1, u_if.x0};

    always_comb begin
        u_if.f_in = 1'b0;
        case (mode)
            1:       u_if.f_in = 1'b1;
            2:       u_if.f_in = u_if.x0;
            3:       u_if.f_in = u_if.x6;
            4:       u_if.f_in = (u_if.x0 & u_if.x2) | (u_if.x0 & u_if.x4) | (u_if.x2 & u_if.x4);
            default: u_if.f_in = 1'b0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_sweep(input int m, input logic [127:0] exp_tt,
                             input logic [7:0] exp_ones, input string tag);
        int lat;
        mode       = m;
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        chk({tag, "_busy_accept"}, {127'd0, u_if.busy}, 128'd1);
        chk({tag, "_x_first"}, {121'd0, w_x}, 128'd0);
        lat = -1;
        for (int n = 1; n <= 200 && lat < 0; n++) begin
            tick();
            if (n == 10) chk({tag, "_tt_partial"}, u_if.tt, exp_tt & 128'h3FF);
            if (n == 37) chk({tag, "_x37"}, {121'd0, w_x}, 128'd37);
            if (u_if.tt_valid) lat = n;
        end
        chk({tag, "_latency"}, 128'(lat), 128'd128);
        chk({tag, "_tt"}, u_if.tt, exp_tt);
`ifdef TT_SWEEP_ONES_COUNT_EN
        chk({tag, "_ones"}, {120'd0, u_if.ones}, {120'd0, exp_ones});
`else
        if (exp_ones == 8'hFF) $display("note: ones value %0d unused", exp_ones);
`endif
        tick();
        chk({tag, "_valid_drop"}, {127'd0, u_if.tt_valid}, 128'd0);
        chk({tag, "_idle_busy"}, {127'd0, u_if.busy}, 128'd0);
        chk({tag, "_tt_hold"}, u_if.tt, exp_tt);
    endtask

    initial begin
        int pulses;
        int first;
        checks     = 0;
        errors     = 0;
        mode       = 0;
        rst        = 1'b1;
        u_if.start = 1'b0;
        tick();
        u_if.start = 1'b1;
        tick();
        chk("rst_busy", {127'd0, u_if.busy}, 128'd0);
        chk("rst_valid", {127'd0, u_if.tt_valid}, 128'd0);
        chk("rst_tt", u_if.tt, 128'd0);
        chk("rst_x", {121'd0, w_x}, 128'd0);
`ifdef TT_SWEEP_ONES_COUNT_EN
        chk("rst_ones", {120'd0, u_if.ones}, 128'd0);
`endif
        u_if.start = 1'b0;
        rst        = 1'b0;
        tick();
        chk("idle_busy", {127'd0, u_if.busy}, 128'd0);

        run_sweep(0, 128'd0, 8'd0,   "zero");
        run_sweep(1, c_ALL1, 8'd128, "one");
        run_sweep(2, c_X0,   8'd64,  "x0");
        run_sweep(3, c_X6,   8'd64,  "x6");
        run_sweep(4, c_MAJ,  8'd64,  "maj");

        // A second start mid-sweep must neither restart nor queue.
        mode       = 2;
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        pulses = 0;
        first  = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (n == 20) u_if.start = 1'b1;
            if (n == 21) u_if.start = 1'b0;
            if (u_if.tt_valid) begin
                pulses++;
                if (first < 0) first = n;
            end
        end
        chk("restart_pulses", 128'(pulses), 128'd1);
        chk("restart_latency", 128'(first), 128'd128);
        chk("restart_tt", u_if.tt, c_X0);

        // Start held high re-arms on every return to IDLE.
        mode       = 1;
        u_if.start = 1'b1;
        tick();
        first = -1;
        for (int n = 1; n <= 200 && first < 0; n++) begin
            tick();
            if (u_if.tt_valid) first = n;
        end
        chk("held_latency", 128'(first), 128'd128);
        tick();
        chk("held_idle", {127'd0, u_if.busy}, 128'd0);
        chk("held_idle_tt", u_if.tt, c_ALL1);
        tick();
        chk("held_rearm", {127'd0, u_if.busy}, 128'd1);
        chk("held_rearm_tt", u_if.tt, 128'd0);
        u_if.start = 1'b0;

        // Reset in the middle of a sweep aborts it silently.
        for (int n = 1; n <= 49; n++) tick();
        chk("abort_busy_before", {127'd0, u_if.busy}, 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {127'd0, u_if.busy}, 128'd0);
        chk("abort_tt", u_if.tt, 128'd0);
        chk("abort_x", {121'd0, w_x}, 128'd0);
`ifdef TT_SWEEP_ONES_COUNT_EN
        chk("abort_ones", {120'd0, u_if.ones}, 128'd0);
`endif
        pulses = 0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (u_if.tt_valid) pulses++;
        end
        chk("abort_no_valid", 128'(pulses), 128'd0);
        chk("abort_idle", {127'd0, u_if.busy}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
